// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: sequences one frequency-counter measurement per request
// and classifies the captured count against latched lo/hi limits.
//
// Ports:
//   ref_clock  - sole clock, rising edge
//   reset      - asynchronous active-low reset
//   req        - level request, sampled in IDLE
//   lo_limit   - minimum acceptable count (latched at start)
//   hi_limit   - maximum acceptable count (latched at start)
//   cnt_rst_n  - active-low clear to the external counter
//   cnt_done   - counter window complete
//   cnt_value  - counter result, quasi-static after cnt_done
//   busy       - high in every state except IDLE
//   ack        - one-cycle pulse, result/status valid from this cycle
//   result     - captured cnt_value
//   status     - 00 in range, 01 too slow, 10 too fast, 11 timeout
//
// Build option: define FREQ_MEAS_TIMEOUT_EN to add a RUN watchdog of
// TIMEOUT cycles; without it RUN waits for cnt_done indefinitely.

module freq_meas_ctrl #(
  parameter int unsigned CLR_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter logic [31:0] TIMEOUT       = 32'd25_000_000
) (
  input  logic        ref_clock,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] lo_limit,
  input  logic [31:0] hi_limit,
  output logic        cnt_rst_n,
  input  logic        cnt_done,
  input  logic [31:0] cnt_value,
  output logic        busy,
  output logic        ack,
  output logic [31:0] result,
  output logic [1:0]  status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_EVAL
  } state_t;

  localparam logic [7:0] CLR_LAST = 8'(CLR_CYCLES - 1);
  localparam logic [7:0] SET_LAST = 8'(SETTLE_CYCLES - 1);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_SLOW = 2'b01;
  localparam logic [1:0] ST_FAST = 2'b10;

`ifdef FREQ_MEAS_TIMEOUT_EN
  localparam logic [1:0]  ST_TMO  = 2'b11;
  localparam logic [31:0] TO_LAST = TIMEOUT - 32'd1;
`endif

  state_t      state;
  logic [7:0]  phase;
  logic [31:0] run_cnt;
  logic [31:0] lo_q;
  logic [31:0] hi_q;
  logic        first_run;
  logic        done_seen;

  // Too-slow is checked first so inverted limits still report 01.
  function automatic logic [1:0] classify(
    input logic [31:0] v,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    logic [1:0] s;
    s = ST_OK;
    if (v < lo)
      s = ST_SLOW;
    else if (v > hi)
      s = ST_FAST;
    return s;
  endfunction

  // run_cnt is cleared at request time, so zero marks RUN cycle 1,
  // where a stale cnt_done from before the clear is ignored.
  assign first_run = (run_cnt == 32'd0);
  assign done_seen = cnt_done && !first_run;

  always_ff @(posedge ref_clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      phase     <= 8'd0;
      run_cnt   <= 32'd0;
      lo_q      <= 32'd0;
      hi_q      <= 32'd0;
      cnt_rst_n <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      result    <= 32'd0;
      status    <= ST_OK;
    end else begin
      ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt_rst_n <= 1'b0;
          busy      <= 1'b0;
          if (req) begin
            lo_q    <= lo_limit;
            hi_q    <= hi_limit;
            run_cnt <= 32'd0;
            phase   <= 8'd0;
            busy    <= 1'b1;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (phase == CLR_LAST) begin
            phase     <= 8'd0;
            cnt_rst_n <= 1'b1;
            state     <= S_RUN;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        S_RUN: begin
          if (run_cnt != 32'hFFFF_FFFF)
            run_cnt <= run_cnt + 32'd1;
          if (done_seen) begin
            phase <= 8'd0;
            state <= S_SETTLE;
          end
`ifdef FREQ_MEAS_TIMEOUT_EN
          else if (run_cnt == TO_LAST) begin
            result <= cnt_value;
            status <= ST_TMO;
            ack    <= 1'b1;
            state  <= S_EVAL;
          end
`endif
        end
        S_SETTLE: begin
          if (phase == SET_LAST) begin
            result <= cnt_value;
            status <= classify(cnt_value, lo_q, hi_q);
            ack    <= 1'b1;
            state  <= S_EVAL;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        S_EVAL: begin
          cnt_rst_n <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          cnt_rst_n <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb_freq_meas_ctrl: directed bench for freq_meas_ctrl with a
// latency/classification model and a per-cycle output compare.

module tb_freq_meas_ctrl;

  localparam int CLR = 4;
  localparam int SET = 3;
  localparam int TO  = 100;
  localparam int BIG = 1 << 30;

  logic        ref_clock = 1'b0;
  logic        reset     = 1'b1;
  logic        req       = 1'b0;
  logic [31:0] lo_limit  = 32'd0;
  logic [31:0] hi_limit  = 32'd0;
  logic        cnt_rst_n;
  logic        cnt_done;
  logic [31:0] cnt_value;
  logic        busy;
  logic        ack;
  logic [31:0] result;
  logic [1:0]  status;

  int n_cmp = 0;
  int n_bad = 0;

  freq_meas_ctrl #(
    .CLR_CYCLES    (CLR),
    .SETTLE_CYCLES (SET),
    .TIMEOUT       (32'(TO))
  ) dut (
    .ref_clock (ref_clock),
    .reset     (reset),
    .req       (req),
    .lo_limit  (lo_limit),
    .hi_limit  (hi_limit),
    .cnt_rst_n (cnt_rst_n),
    .cnt_done  (cnt_done),
    .cnt_value (cnt_value),
    .busy      (busy),
    .ack       (ack),
    .result    (result),
    .status    (status)
  );

  always #5 ref_clock = ~ref_clock;

  // Fake frequency counter: counts cycles out of clear, done after cur_d.
  int          cur_d = 20;
  logic [31:0] cur_v = 32'd0;
  bit          cur_g = 1'b0;
  int          hc = 0;

  always @(posedge ref_clock) hc <= cnt_rst_n ? hc + 1 : 0;

  assign cnt_done  = (cur_d != 0 && hc >= cur_d - 1) || (cur_g && hc == 0);
  assign cnt_value = cur_v;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [1:0] cls(input logic [31:0] v,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    if (v < lo) return 2'd1;
    if (v > hi) return 2'd2;
    return 2'd0;
  endfunction

  function automatic int run_len(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic bit plan_to(input int d);
`ifdef FREQ_MEAS_TIMEOUT_EN
    return d == 0 || run_len(d) > TO;
`else
    return 1'b0 && d == 0;
`endif
  endfunction

  // Edges from acceptance to the ack edge.
  function automatic int plan_l(input int d);
    if (plan_to(d)) return CLR + TO;
    if (d == 0) return BIG;
    return CLR + run_len(d) + SET;
  endfunction

  // Model: k counts edges since acceptance; busy spans k=0..L.
  bit          m_act = 1'b0;
  int          m_k = 0;
  int          m_l = 0;
  bit          m_to = 1'b0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_v  = 32'd0;
  logic [31:0] e_res = 32'd0;
  logic [1:0]  e_st  = 2'd0;

  always @(posedge ref_clock or negedge reset) begin
    if (!reset) begin
      m_act <= 1'b0;
      e_res <= 32'd0;
      e_st  <= 2'd0;
    end else if (m_act) begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_l) begin
        e_res <= m_v;
        e_st  <= m_to ? 2'd3 : cls(m_v, m_lo, m_hi);
      end
      if (m_k + 1 > m_l) m_act <= 1'b0;
    end else if (req) begin
      m_act <= 1'b1;
      m_k   <= 0;
      m_l   <= plan_l(cur_d);
      m_to  <= plan_to(cur_d);
      m_lo  <= lo_limit;
      m_hi  <= hi_limit;
      m_v   <= cur_v;
    end
  end

  always @(negedge ref_clock) begin
    if (reset) begin
      chk("busy", 32'(busy), 32'(m_act));
      chk("ack", 32'(ack), 32'(m_act && m_k == m_l));
      chk("cnt_rst_n", 32'(cnt_rst_n), 32'(m_act && m_k >= CLR));
      chk("result", result, e_res);
      chk("status", 32'(status), 32'(e_st));
    end
  end

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          d;
    logic [31:0] v;
    bit          g;
    logic [31:0] res;
    logic [1:0]  st;
    int          lat;
  } vec_t;

  vec_t tbl[8] = '{
    '{32'd990,  32'd1010, 50, 32'd1000, 1'b0, 32'd1000, 2'd0, 58},
    '{32'd990,  32'd1010, 20, 32'd900,  1'b0, 32'd900,  2'd1, 28},
    '{32'd990,  32'd1010, 20, 32'd1100, 1'b0, 32'd1100, 2'd2, 28},
    '{32'd1010, 32'd990,  20, 32'd1000, 1'b0, 32'd1000, 2'd1, 28},
    '{32'd990,  32'd1010, 1,  32'd990,  1'b0, 32'd990,  2'd0, 10},
    '{32'd990,  32'd1010, 3,  32'd1010, 1'b0, 32'd1010, 2'd0, 11},
    '{32'd990,  32'd1010, 10, 32'd1000, 1'b1, 32'd1000, 2'd0, 18},
    '{32'd1, 32'd10, 4, 32'h8000_0000, 1'b0, 32'h8000_0000, 2'd2, 12}
  };

  // One measurement; req and limits are scrambled after acceptance.
  task automatic meas(input vec_t t, input bit imm);
    int nb = 0;
    int na = 0;
    bit done = 1'b0;
    if (!imm) begin
      @(posedge ref_clock);
      #1;
    end
    cur_d = t.d;
    cur_v = t.v;
    cur_g = t.g;
    lo_limit = t.lo;
    hi_limit = t.hi;
    req = 1'b1;
    @(posedge ref_clock);
    #1;
    req = 1'b0;
    lo_limit = 32'd0;
    hi_limit = 32'd0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge ref_clock);
      if (busy) begin
        nb++;
        if (ack) na++;
      end else begin
        done = 1'b1;
      end
    end
    chk("meas_done", 32'(done), 32'd1);
    chk("latency", nb, t.lat);
    chk("ack_count", na, 32'd1);
    chk("meas_result", result, t.res);
    chk("meas_status", 32'(status), 32'(t.st));
  endtask

  vec_t tv;

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_cnt_rst_n", 32'(cnt_rst_n), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    #20 reset = 1'b1;

    foreach (tbl[i]) meas(tbl[i], 1'b0);

    // Reset in RUN: outputs clear at once, no ack follows.
    begin
      @(posedge ref_clock);
      #1;
      cur_d = 50;
      cur_v = 32'd1000;
      cur_g = 1'b0;
      req = 1'b1;
      @(posedge ref_clock);
      #1;
      req = 1'b0;
      repeat (10) @(posedge ref_clock);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_cnt_rst_n", 32'(cnt_rst_n), 32'd0);
      chk("mid_rst_ack", 32'(ack), 32'd0);
      chk("mid_rst_result", result, 32'd0);
      chk("mid_rst_status", 32'(status), 32'd0);
      @(negedge ref_clock);
      @(negedge ref_clock);
      reset = 1'b1;
      tv = '{32'd990, 32'd1010, 20, 32'd900, 1'b0, 32'd900, 2'd1, 28};
      meas(tv, 1'b1);
    end

    // Back-to-back with req held high.
    begin
      int acks = 0;
      int gaps = 0;
      int lows = 0;
      bit seen = 1'b0;
      bit fin = 1'b0;
      @(posedge ref_clock);
      #1;
      cur_d = 20;
      cur_v = 32'd1000;
      lo_limit = 32'd990;
      hi_limit = 32'd1010;
      req = 1'b1;
      for (int c = 0; c < 500 && !fin; c++) begin
        @(negedge ref_clock);
        if (busy) begin
          seen = 1'b1;
          if (!cnt_rst_n) lows++;
          if (ack) begin
            acks++;
            if (acks == 3) req = 1'b0;
          end
        end else if (seen) begin
          if (acks < 3) gaps++;
          else fin = 1'b1;
        end
      end
      chk("b2b_done", 32'(fin), 32'd1);
      chk("b2b_acks", acks, 32'd3);
      chk("b2b_idle_gaps", gaps, 32'd2);
      chk("b2b_clear_low", lows, 32'd12);
    end

`ifdef FREQ_MEAS_TIMEOUT_EN
    tv = '{32'd990, 32'd1010, 0, 32'd777, 1'b0, 32'd777, 2'd3, 105};
    meas(tv, 1'b0);
    tv = '{32'd990, 32'd1010, 100, 32'd1000, 1'b0, 32'd1000, 2'd0, 108};
    meas(tv, 1'b0);
`else
    begin
      int na = 0;
      @(posedge ref_clock);
      #1;
      cur_d = 0;
      cur_v = 32'd777;
      req = 1'b1;
      @(posedge ref_clock);
      #1;
      req = 1'b0;
      repeat (10000) begin
        @(negedge ref_clock);
        if (ack) na++;
      end
      chk("no_wd_acks", na, 32'd0);
      chk("no_wd_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("no_wd_rst_busy", 32'(busy), 32'd0);
      @(negedge ref_clock);
      reset = 1'b1;
    end
`endif

    tv = '{32'd990, 32'd1010, 20, 32'd1100, 1'b0, 32'd1100, 2'd2, 28};
    meas(tv, 1'b0);
    repeat (3) @(posedge ref_clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_meas_ctrl.md
FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

Interface
REQ-001 SHALL have parameter CLR_CYCLES, default 4, meaning counter-clear hold time in cycles (legal range 2..255).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 3, meaning wait after cnt_done before cnt_value is captured (legal range 1..255).
REQ-003 SHALL have parameter TIMEOUT, default 32'd25_000_000, meaning the RUN watchdog limit in ref_clock cycles.
REQ-004 ref_clock  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req  in  1  level request; a measurement starts when sampled high in IDLE.
REQ-007 lo_limit  in  32  minimum acceptable target count.
REQ-008 hi_limit  in  32  maximum acceptable target count.
REQ-009 cnt_rst_n  out  1  active-low clear to the frequency counter.
REQ-010 cnt_done  in  1  counter window-complete flag, ref_clock domain.
REQ-011 cnt_value  in  32  counter target-clock count, quasi-static after cnt_done.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 ack  out  1  one-cycle pulse; result and status are valid from this cycle.
REQ-014 result  out  32  captured cnt_value.
REQ-015 status  out  2  00 in range, 01 too slow, 10 too fast, 11 timeout.

Function
REQ-016 SHALL implement the FSM states IDLE, CLEAR, RUN, SETTLE and EVAL.
REQ-017 IDLE: cnt_rst_n=0; on req=1, latch lo_limit/hi_limit, clear the cycle counter and go to CLEAR.
REQ-018 CLEAR: cnt_rst_n=0 for exactly CLR_CYCLES cycles, then go to RUN.
REQ-019 RUN: cnt_rst_n=1; cnt_done=1 goes to SETTLE; cnt_done is ignored in the first RUN cycle.
REQ-020 SETTLE: cnt_rst_n=1 for SETTLE_CYCLES cycles, capture cnt_value into result on the last cycle, then go to EVAL.
REQ-021 EVAL: drive ack=1 for one cycle, update status, then go to IDLE.
REQ-022 Total latency from req sampled to ack SHALL be CLR_CYCLES + RUN cycles + SETTLE_CYCLES + 1 cycles.
REQ-023 Classification SHALL be an unsigned 32-bit compare: result < lo_limit gives 01; else result > hi_limit gives 10; else 00.
REQ-024 Inverted limits (lo_limit > hi_limit) SHALL still follow the REQ-023 priority, so too-slow wins.
REQ-025 lo_limit and hi_limit changes while busy SHALL have no effect on the running measurement.
REQ-026 req deassertion while busy SHALL NOT abort the measurement.
REQ-027 req held high through ack SHALL start the next measurement on the cycle after returning to IDLE (back-to-back).
REQ-028 result and status SHALL hold their values until the next EVAL.
REQ-029 The RUN cycle counter SHALL be 32 bits and saturate, never wrap.

Reset
REQ-030 reset low SHALL force, asynchronously, state IDLE, cnt_rst_n=0, busy=0, ack=0, result=0, status=00, latched limits=0 and cycle counter=0.
REQ-031 reset asserted mid-measurement SHALL discard the measurement with no ack.
REQ-032 After reset release the block SHALL accept req on the first rising edge.

Configuration
REQ-033 Macro FREQ_MEAS_TIMEOUT_EN defined: RUN SHALL go to EVAL with status=11 and result=cnt_value sampled at expiry once TIMEOUT cycles elapse without cnt_done.
REQ-034 With FREQ_MEAS_TIMEOUT_EN defined, cnt_done and expiry arriving in the same cycle SHALL be resolved in favour of cnt_done (normal path).
REQ-035 Macro FREQ_MEAS_TIMEOUT_EN undefined: RUN SHALL wait indefinitely, status=11 is never produced, and no watchdog logic SHALL exist.

Verification
REQ-036 Limits 990/1010, counter model done after 50 cycles with value 1000 -> one ack pulse, result=1000, status=00, busy high for 4+50+3+1 cycles.
REQ-037 Value 900, limits 990/1010 -> status=01; value 1100 -> status=10; limits 1010/990 with value 1000 -> status=01.
REQ-038 req held high for 3 measurements -> 3 acks, each subsequent CLEAR begins one cycle after the preceding IDLE re-entry, and cnt_rst_n is low 4 cycles each.
REQ-039 reset pulsed low in RUN -> immediate IDLE, cnt_rst_n=0, no ack, outputs at reset values; the next req completes normally.
REQ-040 FREQ_MEAS_TIMEOUT_EN with TIMEOUT=100 and cnt_done never high -> ack 104+3+1... cycles after req is not applicable, instead ack follows the 100th RUN cycle with status=11; without the macro -> no ack after 10000 cycles.
REQ-041 cnt_done already high when RUN is entered -> it is ignored in RUN cycle 1, and the transition to SETTLE occurs only if cnt_done is still high in RUN cycle 2.
